// File: rtl/port_in_debounce.sv
// Per-bit synchronizer, debouncer and sticky rising-edge flag for processor input ports.
// DEBOUNCE_EN selects the stable-count filter; without it stable follows synced each edge.
module port_in_debounce_bit #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  input  logic clr,
  output logic stable_o,
  output logic event_o
);
  if (SYNC_STAGES < 2 || DB_CYCLES < 2) begin : g_bad_params
    $fatal(1, "port_in_debounce: SYNC_STAGES and DB_CYCLES must be 2 or more");
  end

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   stable_q, stable_d;
  logic                   event_q, event_d;
  logic                   synced;

  assign synced = sync_q[SYNC_STAGES-1];

`ifdef DEBOUNCE_EN
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DB_CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;

  // Any edge where synced matches stable restarts the count from zero.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (synced != stable_q) begin
      if (cnt_q == CNT_MAX) stable_d = synced;
      else                  cnt_d    = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb stable_d = synced;
`endif

  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], raw};
    // Set dominates a coincident clear.
    event_d = (stable_d & ~stable_q) | (event_q & ~clr);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q   <= '0;
      stable_q <= 1'b0;
      event_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      event_q  <= event_d;
    end
  end

  assign stable_o = stable_q;
  assign event_o  = event_q;
endmodule

module port_in_debounce #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] raw_in,
  input  logic [WIDTH-1:0] clr,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] event_out
);
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    port_in_debounce_bit #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CYCLES   (DB_CYCLES)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (raw_in[i]),
      .clr      (clr[i]),
      .stable_o (data_out[i]),
      .event_o  (event_out[i])
    );
  end
endmodule

// File: tb/tb_port_in_debounce.sv
// Directed plus random checks of port_in_debounce against a window-based reference model.
module tb_port_in_debounce;
  localparam int W  = 8;
  localparam int S  = 2;
  localparam int DB = 4;
`ifdef DEBOUNCE_EN
  localparam bit DBE = 1'b1;
`else
  localparam bit DBE = 1'b0;
`endif
  localparam int LAT = DBE ? S + DB : S + 1;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] clr = '0;
  logic [W-1:0] data_out;
  logic [W-1:0] event_out;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] hist[$];
  logic [W-1:0] m_stable;
  logic [W-1:0] m_event;

  port_in_debounce #(.WIDTH(W), .SYNC_STAGES(S), .DB_CYCLES(DB)) dut (
    .clk(clk), .reset(reset), .raw_in(raw_in), .clr(clr),
    .data_out(data_out), .event_out(event_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < S + DB; i++) hist.push_back('0);
    m_stable = '0;
    m_event  = '0;
  endtask

  // A bit flips once the last DB synced samples (raw delayed by S edges) all disagree with it.
  task automatic model_edge(input logic [W-1:0] r, input logic [W-1:0] c);
    logic [W-1:0] nxt, smp;
    bit all_diff;
    nxt = m_stable;
    for (int b = 0; b < W; b++) begin
      if (DBE) begin
        all_diff = 1'b1;
        for (int j = 0; j < DB; j++) begin
          smp = hist[hist.size() - S - j];
          if (smp[b] == m_stable[b]) all_diff = 1'b0;
        end
        if (all_diff) nxt[b] = ~m_stable[b];
      end else begin
        smp = hist[hist.size() - S];
        nxt[b] = smp[b];
      end
    end
    m_event  = (m_event & ~c) | (nxt & ~m_stable);
    m_stable = nxt;
    hist.push_back(r);
    if (hist.size() > 64) void'(hist.pop_front());
  endtask

  task automatic step(input logic [W-1:0] r, input logic [W-1:0] c, input string tag);
    @(negedge clk);
    raw_in = r;
    clr    = c;
    @(posedge clk);
    model_edge(r, c);
    #1;
    chk({tag, ".data"}, data_out, m_stable);
    chk({tag, ".event"}, event_out, m_event);
  endtask

  task automatic pulse_reset(input string tag);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk({tag, ".rst_data"}, data_out, '0);
    chk({tag, ".rst_event"}, event_out, '0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, ".rst_hold_data"}, data_out, '0);
    chk({tag, ".rst_hold_event"}, event_out, '0);
    @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [W-1:0] r, m, c;
    bit seen_glitch;
    model_reset();

    #1;
    chk("por.data", data_out, '0);
    chk("por.event", event_out, '0);
    @(posedge clk);
    #2 reset = 1'b1;

    for (int i = 0; i < 20; i++) begin
      step(8'h00, 8'h00, "idle");
      chk("idle.const", data_out | event_out, 8'h00);
    end

    // Level 0x05 applied before edge 1; first visible after edge LAT.
    for (int i = 1; i <= 8; i++) begin
      step(8'h05, 8'h00, $sformatf("lat%0d", i));
      if (i == LAT - 1) chk("lat.before", data_out, 8'h00);
      if (i == LAT) begin
        chk("lat.at_data", data_out, 8'h05);
        chk("lat.at_event", event_out, 8'h05);
      end
    end
    step(8'h05, 8'h05, "clr05");
    chk("clr05.const", event_out, 8'h00);
    for (int i = 0; i < LAT + 2; i++) step(8'h00, 8'h00, "fall");
    chk("fall.event_kept", event_out, 8'h00);

    // Three-cycle glitch on bit 3.
    seen_glitch = 1'b0;
    for (int i = 0; i < 3 + LAT + 2; i++) begin
      step((i < 3) ? 8'h08 : 8'h00, 8'h00, "glitch");
      if (data_out[3]) seen_glitch = 1'b1;
    end
    chk("glitch.seen", {7'b0, seen_glitch}, {7'b0, !DBE});
    chk("glitch.event3", {7'b0, event_out[3]}, {7'b0, !DBE});
    step(8'h00, 8'hFF, "clr_all");

    // Clear, then set coinciding with clear.
    for (int i = 0; i < LAT; i++) step(8'h01, 8'h00, "rise0");
    chk("rise0.event", event_out, 8'h01);
    step(8'h01, 8'h01, "clr0");
    chk("clr0.event", event_out, 8'h00);
    for (int i = 0; i < LAT + 2; i++) step(8'h00, 8'h00, "fall0");
    for (int i = 0; i < LAT - 1; i++) step(8'h01, 8'h00, "rerise0");
    chk("rerise0.pre", event_out, 8'h00);
    step(8'h01, 8'h01, "setwins");
    chk("setwins.event0", {7'b0, event_out[0]}, 8'h01);
    chk("setwins.data0", {7'b0, data_out[0]}, 8'h01);
    for (int i = 0; i < LAT + 2; i++) step(8'h00, 8'hFF, "settle");

    // Partial count discarded by reset; full latency after release.
    for (int i = 0; i < 3; i++) step(8'hFF, 8'h00, "prerst");
    pulse_reset("midrst");
    for (int i = 1; i <= LAT + 2; i++) begin
      step(8'hFF, 8'h00, $sformatf("postrst%0d", i));
      if (i == LAT - 1) chk("postrst.before", data_out, 8'h00);
      if (i == LAT) begin
        chk("postrst.at_data", data_out, 8'hFF);
        chk("postrst.at_event", event_out, 8'hFF);
      end
    end

    // Random: sparse bit toggles mixed with occasional clears.
    r = 8'hFF;
    for (int i = 0; i < 400; i++) begin
      m = '0;
      for (int b = 0; b < W; b++) if ($urandom_range(0, 9) == 0) m[b] = 1'b1;
      r ^= m;
      c = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      step(r, c, $sformatf("rnd%0d", i));
      if (i == 200) pulse_reset("rndrst");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/port_in_debounce.md
PORT_IN_DEBOUNCE -- requirements
Module: port_in_debounce

Interface
REQ-001 Parameter WIDTH, default 8, number of input bits conditioned.
REQ-002 Parameter SYNC_STAGES, default 2, synchronizer flop depth; legal values 2 or more.
REQ-003 Parameter DB_CYCLES, default 16, consecutive stable synced cycles needed to accept a level change; legal values 2 or more.
REQ-004 Port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-006 Port raw_in, input, WIDTH, asynchronous switch/button levels from the board.
REQ-007 Port clr, input, WIDTH, per-bit clear of event_out, driven from a processor output port.
REQ-008 Port data_out, output, WIDTH, debounced level; feeds processor input port 0.
REQ-009 Port event_out, output, WIDTH, sticky rising-edge flags; feeds processor input port 1.

Function
REQ-010 Each bit SHALL be processed independently, with identical logic per bit.
REQ-011 Each raw_in bit SHALL pass through a SYNC_STAGES-deep flop chain; the last stage is "synced".
REQ-012 Each bit SHALL hold a "stable" register driving data_out, and a counter of width clog2(DB_CYCLES).
REQ-013 When synced equals stable at a clock edge, the counter SHALL be cleared to 0.
REQ-014 When synced differs from stable and the counter is below DB_CYCLES-1, the counter SHALL increment by 1.
REQ-015 When synced differs from stable and the counter equals DB_CYCLES-1, stable SHALL load synced and the counter SHALL clear to 0.
REQ-016 A raw level applied before edge 1 and held SHALL appear on data_out after edge SYNC_STAGES+DB_CYCLES.
REQ-017 A synced pulse shorter than DB_CYCLES cycles SHALL leave data_out unchanged and return the counter to 0.
REQ-018 The counter SHALL never wrap; DB_CYCLES-1 is its maximum value.
REQ-019 event_out[i] SHALL be set on the same edge at which stable[i] transitions 0->1, so it is visible in the same cycle as the data_out rise.
REQ-020 A 1->0 stable transition SHALL NOT affect event_out.
REQ-021 clr[i] high at an edge SHALL clear event_out[i].
REQ-022 If a set and clr[i] coincide on the same edge, the set SHALL win and event_out[i] SHALL be 1.
REQ-023 event_out[i] SHALL remain set until cleared by clr[i] or by reset; repeated rises while set have no further effect.
REQ-024 clr SHALL have no effect on data_out, the counters, or the synchronizers.
REQ-025 Outputs SHALL be driven directly from registers, with no combinational path from raw_in or clr.

Reset
REQ-026 reset low SHALL immediately clear all synchronizer flops, stable registers, counters and event flags to 0, regardless of clk.
REQ-027 data_out and event_out SHALL read 0 while reset is low.
REQ-028 Reset asserted mid-debounce SHALL discard the partial count; after release, counting restarts from 0.
REQ-029 After reset release, an input already high SHALL be treated as a 0->1 change, with full latency and an event set.

Configuration
REQ-030 Macro DEBOUNCE_EN defined: the counter behaviour of REQ-012..REQ-018 SHALL be compiled in.
REQ-031 Macro DEBOUNCE_EN undefined: counters SHALL be omitted, stable SHALL load synced every edge, and the data_out latency SHALL be SYNC_STAGES+1 edges.
REQ-032 Event behaviour (REQ-019..REQ-023) SHALL be identical in both configurations.

Verification (WIDTH=8, SYNC_STAGES=2, DB_CYCLES=4, DEBOUNCE_EN defined unless noted)
REQ-033 Reset low then high, raw_in=0x00 -> data_out=0x00 and event_out=0x00 for 20 cycles.
REQ-034 raw_in 0x00->0x05 before edge 1 and held -> data_out=0x05 and event_out=0x05 first visible after edge 6, not after edge 5.
REQ-035 raw_in bit 3 high for 3 cycles then low -> data_out[3] and event_out[3] stay 0 throughout.
REQ-036 event_out=0x01, clr=0x01 for one edge -> event_out=0x00; a new rise of bit 0 coincident with clr=0x01 -> event_out[0]=1.
REQ-037 raw_in=0xFF held for 3 synced cycles, reset pulsed low, then released -> outputs 0 during reset; 0xFF appears 6 edges after release with event_out=0xFF.
REQ-038 DEBOUNCE_EN undefined, raw_in 0x00->0x80 before edge 1 -> data_out=0x80 after edge 3, and a 1-cycle glitch propagates to data_out.
